mul_seq: RTL and testbench

- Multi-cycle sequencer in the EX stage that feeds the combinational signed multiplier and captures its product.
- Latches MUL operands and the destination register when a MUL issues, and holds them stable on the multiplier inputs for LATENCY cycles.
- Stalls the pipeline while the product settles, then presents the low 64 bits with a one-cycle done pulse to the EX/MEM register.
- Lets synthesis treat the multiplier as a multicycle path instead of a single-cycle critical path.

---
 rtl/mul_seq_pkg.sv | 14 +
 rtl/mul_seq_mult.sv | 19 +
 rtl/mul_seq.sv | 115 +++++++++++
 tb/tb_mul_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared CPU definitions used by the EX-stage multiply sequencer.
// Holds the sequencer state encoding and the datapath/register-index widths.
package cpu_pkg;

  localparam int DATA_W = 64;
  localparam int REG_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_seq_mult.sv
// Combinational signed multiplier; only the low WIDTH bits of the product are kept.
// Driven from held registers, so it may be timed as a multicycle path.
module mult
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_low
);

  logic signed [WIDTH-1:0] w_prod;

  // The low half of a two's complement product does not depend on signedness.
  assign w_prod = $signed(i_a) * $signed(i_b);
  assign o_low  = w_prod;

endmodule

// File: rtl/mul_seq.sv
// EX-stage multiply sequencer: latches a MUL, holds the multiplier inputs for
// LATENCY cycles while stalling the pipeline, then pulses done with the product.
module mul_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH   = DATA_W,
  parameter int LATENCY = 2,
  parameter int RD_W    = REG_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  input  logic [RD_W-1:0]  i_rd_in,
  output logic             o_stall,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic [RD_W-1:0]  o_rd_out
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  mul_state_t       r_state;
  mul_state_t       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [RD_W-1:0]  r_rd;
  logic [WIDTH-1:0] r_result;
  logic [RD_W-1:0]  r_rd_out;
  logic [WIDTH-1:0] w_mult_low;
  logic             w_accept;

  assign w_accept = i_start & ~i_flush;

  mult #(
    .WIDTH (WIDTH)
  ) u_mult (
    .i_a   (r_op_a),
    .i_b   (r_op_b),
    .o_low (w_mult_low)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next_state = RUN;
      end
      RUN: begin
        if (i_flush)             w_next_state = IDLE;
        else if (r_cnt == '0)    w_next_state = DONE;
      end
      DONE: begin
        w_next_state = w_accept ? RUN : IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Operands are only reloaded on acceptance, so the multiplier inputs stay put through DONE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_rd     <= '0;
      r_result <= '0;
      r_rd_out <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_op_a <= i_op_a;
            r_op_b <= i_op_b;
            r_rd   <= i_rd_in;
            r_cnt  <= CNT_W'(LATENCY - 1);
          end
        end
        RUN: begin
          if (!i_flush) begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - CNT_W'(1);
            end else begin
              r_result <= w_mult_low;
              r_rd_out <= r_rd;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_busy  = (r_state == RUN);
    o_done  = (r_state == DONE);
    o_stall = o_busy | (w_accept & (r_state != RUN));
  end

  assign o_result = r_result;
  assign o_rd_out = r_rd_out;

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: stimulus pushes expected {result, rd} into a
// scoreboard queue and a negedge monitor pops and compares on every done pulse.
module tb_mul_seq;

  localparam int W   = 64;
  localparam int RW  = 5;
  localparam int LAT = 2;

  typedef struct {
    logic [W-1:0]  res;
    logic [RW-1:0] rd;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          flush;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [RW-1:0] rd_in;
  logic          stall;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic [RW-1:0] rd_out;

  exp_t sbQ[$];
  int   checks;
  int   errors;

  mul_seq #(
    .WIDTH   (W),
    .LATENCY (LAT),
    .RD_W    (RW)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_flush  (flush),
    .i_op_a   (op_a),
    .i_op_b   (op_b),
    .i_rd_in  (rd_in),
    .o_stall  (stall),
    .o_busy   (busy),
    .o_done   (done),
    .o_result (result),
    .o_rd_out (rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one MUL for a single cycle; optionally records its expected response.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [RW-1:0] rd, input logic [W-1:0] expRes,
                               input bit doPush);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    rd_in = rd;
    if (doPush) begin
      e.res = expRes;
      e.rd  = rd;
      sbQ.push_back(e);
    end
    @(negedge clk);
    checkOutput("issue_stall", {63'd0, stall}, 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int  runCycles;
    bit  seen;
    runCycles = 0;
    seen      = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy && stall) runCycles++;
    end
    checkOutput({name, "_done_seen"}, {63'd0, seen}, 64'd1);
    checkOutput({name, "_run_cycles"}, 64'(runCycles), 64'(LAT));
    checkOutput({name, "_stall_in_done"}, {63'd0, stall}, 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got result %h rd %0d expected no done", result, rd_out);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("sb_result", result, e.res);
        checkOutput("sb_rd", {59'd0, rd_out}, {59'd0, e.rd});
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    op_a   = '0;
    op_b   = '0;
    rd_in  = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_result", result, 64'd0);
    checkOutput("rst_rd", {59'd0, rd_out}, 64'd0);
    checkOutput("rst_flags", {61'd0, stall, busy, done}, 64'd0);
    rst_n = 1'b1;

    repeat (4) begin
      @(negedge clk);
      checkOutput("idle_flags", {61'd0, stall, busy, done}, 64'd0);
    end

    applyStimulus(64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 5'd7, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1);
    waitDone("basic");

    applyStimulus(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 64'h8000_0000_0000_0000, 1'b1);
    waitDone("wrap_min");

    applyStimulus(64'h1_0000_0000, 64'h1_0000_0000, 5'd31, 64'd0, 1'b1);
    waitDone("wrap_zero");

    // Back-to-back: second MUL issued during the DONE cycle of the first.
    applyStimulus(64'd11, 64'd13, 5'd4, 64'd143, 1'b1);
    @(posedge clk);
    @(posedge clk); #1;
    start = 1'b1;
    op_a  = 64'd5;
    op_b  = 64'd6;
    rd_in = 5'd9;
    begin
      exp_t e;
      e.res = 64'd30;
      e.rd  = 5'd9;
      sbQ.push_back(e);
    end
    @(negedge clk);
    checkOutput("b2b_first_done", {63'd0, done}, 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    waitDone("b2b_second");

    // Flush in the first RUN cycle discards the MUL.
    applyStimulus(64'd4, 64'd4, 5'd12, 64'd16, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_busy_before", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_idle", {62'd0, stall, busy}, 64'd0);
    checkOutput("flush_result_kept", result, 64'd30);
    checkOutput("flush_rd_kept", {59'd0, rd_out}, 64'd9);
    repeat (5) @(negedge clk);

    // Flush together with start: not accepted.
    @(posedge clk); #1;
    start = 1'b1;
    flush = 1'b1;
    op_a  = 64'd4;
    op_b  = 64'd4;
    @(negedge clk);
    checkOutput("flush_start_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_start_busy", {63'd0, busy}, 64'd0);
    repeat (4) @(negedge clk);

    // Asynchronous reset between edges during RUN.
    applyStimulus(64'd7, 64'd7, 5'd1, 64'd49, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_flags", {61'd0, stall, busy, done}, 64'd0);
    checkOutput("async_rst_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("post_rst_idle", {61'd0, stall, busy, done}, 64'd0);

    applyStimulus(64'hFFFF_FFFF_FFFF_FFFB, 64'd9, 5'd20, 64'hFFFF_FFFF_FFFF_FFD3, 1'b1);
    waitDone("post_rst_mul");

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", 64'(sbQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
